// File: rtl/banked_byte_memory_pkg.sv
// rtl/banked_byte_memory_pkg.sv - shared size codes, FSM state type and extension helper
// Purpose: common definitions for banked_byte_memory and its lane RAMs.
// Ports:   none (package).
package banked_byte_memory_pkg;

   // req_size encoding: log2 of the access width in bytes
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPLIT    = 2'd1,
      RESP_ERR = 2'd2
   } state_t;

   // Number of significant read bits for an access of 2^size lanes
   function automatic int unsigned ext_width(input logic [1:0] size, input int unsigned lane_w);
      return lane_w << size;
   endfunction

endpackage

// File: rtl/banked_byte_memory_lane_ram.sv
// rtl/banked_byte_memory_lane_ram.sv - single-port lane RAM with synchronous read
// Purpose: one byte lane of the banked memory; read-first on a same-edge write.
// Ports:   clk            rising-edge clock
//          we             write enable for this lane
//          addr [AW]      word address
//          wdata [LANE_W] write data
//          rdata [LANE_W] registered read data of the word addressed at the last edge
module lane_ram
   import banked_byte_memory_pkg::*;
#(
   parameter int LANE_W = 8,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [LANE_W-1:0] wdata,
   output logic [LANE_W-1:0] rdata
);

   logic [LANE_W-1:0] mem_q [0:(1<<AW)-1];
   logic [LANE_W-1:0] rdata_q;

   // Contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/banked_byte_memory.sv
// rtl/banked_byte_memory.sv - byte-lane memory with sized, extended and split accesses
// Purpose: LANES lane RAMs behind a valid/ready request port; byte/half/word accesses at
//          any alignment, word-crossing accesses split over two cycles, sign/zero-extended reads.
// Ports:   clk, rst (async, active-high)
//          req_valid/req_ready handshake; req_we, req_size, req_unsigned, req_addr, req_wdata
//          rsp_valid (1-cycle pulse per request), rsp_rdata (extended read data), rsp_err (illegal size)
module banked_byte_memory
   import banked_byte_memory_pkg::*;
#(
   parameter int LANE_W = 8,
   parameter int LANES  = 4,
   parameter int ADDR_W = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [1:0]              req_size,
   input  logic                    req_unsigned,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [LANES*LANE_W-1:0] req_wdata,
   output logic                    rsp_valid,
   output logic [LANES*LANE_W-1:0] rsp_rdata,
   output logic                    rsp_err
);

   localparam int OFF_W  = $clog2(LANES);
   localparam int WORD_W = ADDR_W - OFF_W;
   localparam int DATA_W = LANES * LANE_W;
   localparam logic [1:0]     MAX_SIZE = (OFF_W >= 3) ? 2'd3 : 2'(OFF_W);
   localparam logic [OFF_W:0] ONE_N    = {{OFF_W{1'b0}}, 1'b1};
   localparam logic [OFF_W:0] LANES_N  = {1'b1, {OFF_W{1'b0}}};

   // ---------------------------------------------------------------- request decode
   logic [OFF_W-1:0] req_off;
   logic [OFF_W:0]   req_nbytes;
   logic             req_legal;
   logic             req_split;

   assign req_off    = req_addr[OFF_W-1:0];
   assign req_nbytes = ONE_N << req_size;
   assign req_legal  = (req_size <= MAX_SIZE);
   assign req_split  = ({1'b0, req_off} + req_nbytes) > LANES_N;

   // ---------------------------------------------------------------- state
   state_t              state_q, state_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_we_q, rsp_we_d;
   logic                rsp_unsigned_q, rsp_unsigned_d;
   logic                rsp_split_q, rsp_split_d;
   logic [1:0]          rsp_size_q, rsp_size_d;
   logic [OFF_W-1:0]    rsp_off_q, rsp_off_d;
   logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
   logic [1:0]          hold_size_q, hold_size_d;
   logic                hold_unsigned_q, hold_unsigned_d;
   logic                hold_we_q, hold_we_d;
   logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
   logic [DATA_W-1:0]   hold_rdata_q, hold_rdata_d;

   // Access presented to the lane RAMs this cycle
   logic                acc_en;
   logic                acc_second;
   logic [ADDR_W-1:0]   acc_addr;
   logic [1:0]          acc_size;
   logic                acc_we;
   logic [DATA_W-1:0]   acc_wdata;

   logic [DATA_W-1:0]   lane_rdata;

   always_comb begin
      state_d         = state_q;
      rsp_valid_d     = 1'b0;
      rsp_err_d       = 1'b0;
      rsp_we_d        = rsp_we_q;
      rsp_unsigned_d  = rsp_unsigned_q;
      rsp_split_d     = rsp_split_q;
      rsp_size_d      = rsp_size_q;
      rsp_off_d       = rsp_off_q;
      hold_addr_d     = hold_addr_q;
      hold_size_d     = hold_size_q;
      hold_unsigned_d = hold_unsigned_q;
      hold_we_d       = hold_we_q;
      hold_wdata_d    = hold_wdata_q;
      hold_rdata_d    = hold_rdata_q;
      acc_en          = 1'b0;
      acc_second      = 1'b0;
      acc_addr        = req_addr;
      acc_size        = req_size;
      acc_we          = req_we;
      acc_wdata       = req_wdata;
      req_ready       = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (!req_legal) begin
                  state_d = RESP_ERR;
               end else begin
                  acc_en = 1'b1;
                  if (req_split) begin
                     state_d         = SPLIT;
                     hold_addr_d     = req_addr;
                     hold_size_d     = req_size;
                     hold_unsigned_d = req_unsigned;
                     hold_we_d       = req_we;
                     hold_wdata_d    = req_wdata;
                  end else begin
                     rsp_valid_d    = 1'b1;
                     rsp_we_d       = req_we;
                     rsp_unsigned_d = req_unsigned;
                     rsp_size_d     = req_size;
                     rsp_off_d      = req_off;
                     rsp_split_d    = 1'b0;
                  end
               end
            end
         end
         SPLIT: begin
            acc_en         = 1'b1;
            acc_second     = 1'b1;
            acc_addr       = hold_addr_q;
            acc_size       = hold_size_q;
            acc_we         = hold_we_q;
            acc_wdata      = hold_wdata_q;
            // The synchronous read only presents word W now, so the first-half
            // bytes are captured here rather than at the acceptance edge.
            hold_rdata_d   = lane_rdata;
            rsp_valid_d    = 1'b1;
            rsp_we_d       = hold_we_q;
            rsp_unsigned_d = hold_unsigned_q;
            rsp_size_d     = hold_size_q;
            rsp_off_d      = hold_addr_q[OFF_W-1:0];
            rsp_split_d    = 1'b1;
            state_d        = IDLE;
         end
         RESP_ERR: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         rsp_valid_q     <= 1'b0;
         rsp_err_q       <= 1'b0;
         rsp_we_q        <= 1'b0;
         rsp_unsigned_q  <= 1'b0;
         rsp_split_q     <= 1'b0;
         rsp_size_q      <= '0;
         rsp_off_q       <= '0;
         hold_addr_q     <= '0;
         hold_size_q     <= '0;
         hold_unsigned_q <= 1'b0;
         hold_we_q       <= 1'b0;
         hold_wdata_q    <= '0;
         hold_rdata_q    <= '0;
      end else begin
         state_q         <= state_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_err_q       <= rsp_err_d;
         rsp_we_q        <= rsp_we_d;
         rsp_unsigned_q  <= rsp_unsigned_d;
         rsp_split_q     <= rsp_split_d;
         rsp_size_q      <= rsp_size_d;
         rsp_off_q       <= rsp_off_d;
         hold_addr_q     <= hold_addr_d;
         hold_size_q     <= hold_size_d;
         hold_unsigned_q <= hold_unsigned_d;
         hold_we_q       <= hold_we_d;
         hold_wdata_q    <= hold_wdata_d;
         hold_rdata_q    <= hold_rdata_d;
      end
   end

   // ---------------------------------------------------------------- lanes
   logic [OFF_W-1:0]  acc_off;
   logic [OFF_W:0]    acc_nbytes;
   logic [WORD_W-1:0] acc_word;
   logic [WORD_W-1:0] acc_word_sel;

   assign acc_off      = acc_addr[OFF_W-1:0];
   assign acc_nbytes   = ONE_N << acc_size;
   assign acc_word     = acc_addr[ADDR_W-1:OFF_W];
   // Word W+1 wraps naturally at the top of the array
   assign acc_word_sel = acc_second ? (acc_word + WORD_W'(1)) : acc_word;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [OFF_W-1:0]  rel;
      logic              in_acc;
      logic              upper_part;
      logic              lane_we;
      logic [LANE_W-1:0] lane_rd;

      // rel: which byte of the access this lane carries (mod LANES)
      assign rel        = OFF_W'(l) - acc_off;
      assign in_acc     = ({1'b0, rel} < acc_nbytes);
      // Lanes at or above the offset belong to word W, lower lanes to word W+1
      assign upper_part = (OFF_W'(l) >= acc_off);
      assign lane_we    = acc_en && acc_we && in_acc && (acc_second ? !upper_part : upper_part);

      lane_ram #(
         .LANE_W (LANE_W),
         .AW     (WORD_W)
      ) u_lane_ram (
         .clk   (clk),
         .we    (lane_we),
         .addr  (acc_word_sel),
         .wdata (acc_wdata[rel*LANE_W +: LANE_W]),
         .rdata (lane_rd)
      );

      assign lane_rdata[l*LANE_W +: LANE_W] = lane_rd;
   end

   // ---------------------------------------------------------------- read response
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] rotated;
   logic [DATA_W-1:0] extended;
   int                ext_bits;
   logic              sign_bit;

   for (genvar l = 0; l < LANES; l++) begin : g_merge
      assign merged[l*LANE_W +: LANE_W] = (rsp_split_q && (OFF_W'(l) >= rsp_off_q)) ?
                                          hold_rdata_q[l*LANE_W +: LANE_W] :
                                          lane_rdata[l*LANE_W +: LANE_W];
   end

   for (genvar i = 0; i < LANES; i++) begin : g_rot
      logic [OFF_W-1:0] src;
      assign src = rsp_off_q + OFF_W'(i);
      assign rotated[i*LANE_W +: LANE_W] = merged[src*LANE_W +: LANE_W];
   end

   always_comb begin
      ext_bits = int'(ext_width(rsp_size_q, LANE_W));
      sign_bit = rotated[ext_bits-1] & ~rsp_unsigned_q;
      for (int b = 0; b < DATA_W; b++) begin
         extended[b] = (b < ext_bits) ? rotated[b] : sign_bit;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !rsp_we_q) ? extended : '0;

endmodule

// File: tb/tb_banked_byte_memory.sv
// tb/tb_banked_byte_memory.sv - scoreboard bench with byte-array reference model
module tb_banked_byte_memory;

   localparam int LANE_W    = 8;
   localparam int LANES     = 4;
   localparam int ADDR_W    = 10;
   localparam int MEM_BYTES = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      time         t_due;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] model_mem [0:MEM_BYTES-1];

   always #5 clk = ~clk;

   banked_byte_memory #(
      .LANE_W (LANE_W),
      .LANES  (LANES),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Reference read: plain byte addressing modulo the array size
   function automatic logic [31:0] model_read(input int addr, input int size, input logic uns);
      logic [31:0] v;
      int n;
      v = 32'd0;
      n = 1 << size;
      for (int i = 0; i < n; i++) begin
         v = v | (32'(model_mem[(addr + i) % MEM_BYTES]) << (8 * i));
      end
      if (!uns && n < 4 && v[8*n-1]) begin
         v = v | ~((32'd1 << (8 * n)) - 32'd1);
      end
      return v;
   endfunction

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wdata);
      int   waited;
      int   n;
      bit   two_cycle;
      exp_t e;
      waited       = 0;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(negedge clk);
      while (!req_ready && waited < 8) begin
         waited++;
         @(negedge clk);
      end
      if (!req_ready) begin
         check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      e.t_due = $time + 5;
      if (size > 2'd2) begin
         e.err     = 1'b1;
         e.rdata   = 32'd0;
         two_cycle = 1'b1;
      end else begin
         n         = 1 << size;
         two_cycle = ((int'(addr) % LANES) + n) > LANES;
         e.err     = 1'b0;
         if (we) begin
            for (int i = 0; i < n; i++) begin
               model_mem[(int'(addr) + i) % MEM_BYTES] = wdata[8*i +: 8];
            end
            e.rdata = 32'd0;
         end else begin
            e.rdata = model_read(int'(addr), int'(size), uns);
         end
      end
      if (two_cycle) begin
         e.t_due = e.t_due + 10;
      end
      exp_q.push_back(e);
      #1 req_valid = 1'b0;
      if (two_cycle) begin
         @(negedge clk);
         check("req_ready_second_cycle", {31'b0, req_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pops one expectation per response pulse
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 rdata %h, expected no response", rsp_rdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_time", 32'($time), 32'(mon_e.t_due));
            check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
            check("rsp_rdata", rsp_rdata, mon_e.rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      logic [1:0] sz;
      logic [9:0] ad;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      repeat (2) @(negedge clk);
      check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Give every byte a known value
      for (int w = 0; w < MEM_BYTES / LANES; w++) begin
         issue(1'b1, 2'd2, 1'b0, 10'(w * LANES), $urandom);
      end

      // Aligned write then byte read
      issue(1'b1, 2'd2, 1'b0, 10'h010, 32'h11223344);
      issue(1'b0, 2'd0, 1'b0, 10'h012, 32'h0);
      // Sign / zero extension
      issue(1'b1, 2'd0, 1'b0, 10'h020, 32'h00000080);
      issue(1'b0, 2'd0, 1'b0, 10'h020, 32'h0);
      issue(1'b0, 2'd0, 1'b1, 10'h020, 32'h0);
      // Split read across words 4 and 5
      issue(1'b1, 2'd2, 1'b0, 10'h014, 32'hAABBCCDD);
      issue(1'b0, 2'd1, 1'b0, 10'h013, 32'h0);
      // Wrap-around from the top word to word 0
      issue(1'b1, 2'd2, 1'b0, 10'h3FE, 32'hCAFEBABE);
      issue(1'b0, 2'd2, 1'b1, 10'h3FC, 32'h0);
      issue(1'b0, 2'd2, 1'b1, 10'h000, 32'h0);
      // Illegal size leaves memory untouched
      issue(1'b1, 2'd3, 1'b0, 10'h040, 32'hDEADBEEF);
      issue(1'b0, 2'd2, 1'b1, 10'h040, 32'h0);

      // Reset during the second cycle of a split word write at 0x005
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_addr     = 10'h005;
      req_wdata    = 32'h5A6B7C8D;
      @(negedge clk);
      check("ready_before_split_reset", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         model_mem[5 + i] = req_wdata[8*i +: 8];
      end
      #2;
      rst       = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rsp_valid_in_reset", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("ready_after_split_reset", {31'b0, req_ready}, 32'd1);
      check("no_rsp_after_split_reset", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      issue(1'b0, 2'd2, 1'b1, 10'h004, 32'h0);
      issue(1'b0, 2'd2, 1'b1, 10'h008, 32'h0);

      // Randomized traffic concentrated on a few words to hit read-after-write
      for (int k = 0; k < 400; k++) begin
         sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         ad = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 63));
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
      end

      repeat (4) @(negedge clk);
      check("responses_outstanding", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/banked_byte_memory.md
# banked_byte_memory

Parametrised byte-lane memory built from LANES independent LANE_W-bit lane RAMs, the successor to the fixed four-lane word memory. Adds per-access size (byte/half/word), sign/zero extension on reads, lane-masked writes, and automatic two-cycle splitting of accesses that cross a word boundary. It sits behind the core's load/store unit or instruction fetch port. A valid/ready request handshake and a single-cycle response pulse connect it to the core.

## Interface
- LANE_W, 8, bits per lane (one byte).
- LANES, 4, lanes per word; power of two, ≥2.
- ADDR_W, 10, byte-address width; the array holds 2^ADDR_W bytes, i.e. 2^ADDR_W/LANES words per lane.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset: asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted at an edge where req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word. Legal only when ≤ log2(LANES).
- req_unsigned  in  1  reads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address; any alignment is allowed.
- req_wdata  in  LANES*LANE_W  write data, right-justified (the lowest byte goes to req_addr).
- rsp_valid  out  1  one-cycle pulse per accepted request, for reads and writes.
- rsp_rdata  out  LANES*LANE_W  read result, right-justified and extended. 0 for writes and errors.
- rsp_err  out  1  qualified by rsp_valid: illegal size.

## Operation
- Let o = req_addr mod LANES, W = req_addr / LANES, and n = 2^req_size bytes.
- Byte i of the access (i = 0..n-1) maps to lane (o+i) mod LANES of word W, or of word W+1 when o+i ≥ LANES.
- Word W+1 wraps modulo the word count: the top word is followed by word 0.
- Writes: only the addressed lanes get a write enable. Every other lane and every other word is left unchanged.
- Reads: bytes are rotated so that byte 0 lands in bits [LANE_W-1:0]. The result is then zero- or sign-extended from bit n*LANE_W-1.
- FSM with states IDLE, SPLIT, RESP_ERR:
  - IDLE: req_ready = 1.
  - Accept a legal access with o+n ≤ LANES: perform it at the acceptance edge and stay in IDLE.
  - Accept a legal access with o+n > LANES: perform the word-W part, latch the request (addr, size, unsigned, wdata) and the first-half read bytes into a hold register, then go to SPLIT.
  - Accept an illegal size: no RAM access; go to RESP_ERR.
  - SPLIT: req_ready = 0. Perform the word-W+1 part, then go to IDLE. The response merges the held bytes with the new bytes.
  - RESP_ERR: req_ready = 0. Drive rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, then go to IDLE.
- Reset:
  - FSM goes to IDLE; rsp_valid, rsp_err and rsp_rdata clear to 0; req_ready reads 1 once rst deasserts.
  - RAM contents are not reset.
  - Reset during SPLIT abandons the access. A first-half write stays committed, no second half is written, and no response is produced.

## Timing
- Lane RAMs have a synchronous read and write; the read happens in the same edge as the access.
- Non-split access accepted at edge t:
  - rsp_valid = 1 in the cycle after t.
  - Back-to-back acceptance on every cycle is supported (throughput 1/cycle).
- Split access accepted at edge t:
  - Second part at edge t+1; req_ready = 0 in the cycle between.
  - rsp_valid = 1 in the cycle after t+1.
- Illegal size accepted at edge t: rsp_valid = 1 with rsp_err = 1 in the cycle after t+1, matching split timing.
- Responses are returned in request order. There is no response back-pressure.
- A read that follows a write to the same bytes on the next cycle returns the new data.

## Structure
- Shared package holds:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state typedef;
  - a function for byte-extension width.
- Sub-module lane_ram (LANE_W × 2^ADDR_W/LANES, sync read, single port with write enable), instantiated LANES times in a generate loop.
- The lane-mask, rotate and extend logic plus the FSM stay in the top level.

## Test plan
- Aligned write and read (LANES=4, ADDR_W=10): word write 0x11223344 @0x010, then signed byte read @0x012 → rsp_rdata 0x00000022 one cycle after acceptance; rsp_err = 0.
- Sign extension: write byte 0x80 @0x020; signed byte read → 0xFFFFFF80; unsigned byte read → 0x00000080.
- Split read:
  - Setup: 0x11223344 @0x010 and 0xAABBCCDD @0x014.
  - Stimulus: signed half read @0x013.
  - Required: req_ready = 0 for one cycle; rsp 0xFFFFDD11 two cycles after acceptance.
- Wrap-around: word write 0xCAFEBABE @0x3FE → bytes @0x3FE/0x3FF = BE/BA and @0x000/0x001 = FE/CA; other bytes of words 0xFF and 0x00 are unchanged.
- Illegal size: req_size = 3 write @0x040 → rsp_valid with rsp_err = 1 and rdata 0 two cycles after acceptance; a subsequent read @0x040 returns the prior contents.
- Reset mid-split: split word write @0x005, with rst asserted during SPLIT → no rsp_valid; bytes 0x005–0x007 are written; byte 0x008 is unchanged; req_ready = 1 after release.
